// File: rtl/traffic_light_monitor_if.sv
// Lamp bus between a three-phase traffic light controller and its consumers.
// The controller drives all six lamps; the monitor only observes them.
interface traffic_light_monitor_if;
    logic NS_green;
    logic NS_yellow;
    logic NS_red;
    logic EW_green;
    logic EW_yellow;
    logic EW_red;

    modport master (
        output NS_green, NS_yellow, NS_red,
        output EW_green, EW_yellow, EW_red
    );

    modport slave (
        input NS_green, NS_yellow, NS_red,
        input EW_green, EW_yellow, EW_red
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive traffic light sequence checker.
// Decodes the six lamps into a phase each clock, enforces the
// NS_GO -> ALL_YELLOW -> EW_GO -> NS_GO order and per-phase dwell limits,
// latches the first violation as a sticky fault and counts completed cycles.
//
// state | meaning
// ------+-----------------------------------------------------------------
// SYNC  | waiting for the first decodable lamp pattern; junk is ignored
// TRACK | following the sequence and checking order/dwell every clock
// FAULT | first violation latched; phase, dwell and cycle_count frozen
module traffic_light_monitor #(
    parameter int MIN_DWELL = 2,
    parameter int MAX_DWELL = 2,
    parameter int DWELL_W   = 4,
    parameter int CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    traffic_light_monitor_if.slave   lamps,
    output logic [1:0]               phase,
    output logic                     phase_valid,
    output logic [DWELL_W-1:0]       dwell,
    output logic [CNT_W-1:0]         cycle_count,
    output logic                     fault,
    output logic [2:0]               fault_code
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [1:0] PH_NS_GO      = 2'd0;
    localparam logic [1:0] PH_ALL_YELLOW = 2'd1;
    localparam logic [1:0] PH_EW_GO      = 2'd2;

    localparam logic [2:0] FC_ILLEGAL_COMBO = 3'd1;
    localparam logic [2:0] FC_BAD_ORDER     = 3'd2;
    localparam logic [2:0] FC_SHORT_DWELL   = 3'd3;
    localparam logic [2:0] FC_LONG_DWELL    = 3'd4;

    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
    localparam logic [DWELL_W-1:0] DWELL_MIN = DWELL_W'(MIN_DWELL);
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(MAX_DWELL);

    state_t               state;
    logic                 first_phase;

    logic                 dec_ok;
    logic [1:0]           dec_phase;
    logic [1:0]           succ_phase;
    logic [DWELL_W-1:0]   dwell_inc;

    logic [2:0]           ns_lamps;
    logic [2:0]           ew_lamps;

    assign ns_lamps = {lamps.NS_green, lamps.NS_yellow, lamps.NS_red};
    assign ew_lamps = {lamps.EW_green, lamps.EW_yellow, lamps.EW_red};

    // Decode the current lamp sample; each side must show exactly the one
    // lamp its phase calls for, anything else is undecodable.
    always_comb begin
        dec_ok    = 1'b0;
        dec_phase = PH_NS_GO;
        if (ns_lamps == 3'b100 && ew_lamps == 3'b001) begin
            dec_ok    = 1'b1;
            dec_phase = PH_NS_GO;
        end else if (ns_lamps == 3'b010 && ew_lamps == 3'b010) begin
            dec_ok    = 1'b1;
            dec_phase = PH_ALL_YELLOW;
        end else if (ns_lamps == 3'b001 && ew_lamps == 3'b100) begin
            dec_ok    = 1'b1;
            dec_phase = PH_EW_GO;
        end
    end

    // Only legal successor of the stored phase, and the saturating dwell step.
    always_comb begin
        succ_phase = PH_NS_GO;
        case (phase)
            PH_NS_GO:      succ_phase = PH_ALL_YELLOW;
            PH_ALL_YELLOW: succ_phase = PH_EW_GO;
            PH_EW_GO:      succ_phase = PH_NS_GO;
            default:       succ_phase = PH_NS_GO;
        endcase
        dwell_inc = (dwell == '1) ? dwell : dwell + DWELL_ONE;
    end

    // Sequence checker FSM; all outputs registered here, reset wins over all.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_SYNC;
            first_phase <= 1'b0;
            phase       <= PH_NS_GO;
            phase_valid <= 1'b0;
            dwell       <= '0;
            cycle_count <= '0;
            fault       <= 1'b0;
            fault_code  <= 3'd0;
        end else begin
            case (state)
                ST_SYNC: begin
                    if (dec_ok) begin
                        state       <= ST_TRACK;
                        phase       <= dec_phase;
                        phase_valid <= 1'b1;
                        dwell       <= DWELL_ONE;
                        first_phase <= 1'b1;
                    end
                end

                ST_TRACK: begin
                    if (!dec_ok) begin
                        state      <= ST_FAULT;
                        fault      <= 1'b1;
                        fault_code <= FC_ILLEGAL_COMBO;
                    end else if (dec_phase == phase) begin
                        // The dwell still advances on the sample that overruns.
                        dwell <= dwell_inc;
                        if (!first_phase && dwell_inc > DWELL_MAX) begin
                            state      <= ST_FAULT;
                            fault      <= 1'b1;
                            fault_code <= FC_LONG_DWELL;
                        end
                    end else if (dec_phase != succ_phase) begin
                        state      <= ST_FAULT;
                        fault      <= 1'b1;
                        fault_code <= FC_BAD_ORDER;
                    end else if (!first_phase && dwell < DWELL_MIN) begin
                        state      <= ST_FAULT;
                        fault      <= 1'b1;
                        fault_code <= FC_SHORT_DWELL;
                    end else begin
                        phase       <= dec_phase;
                        dwell       <= DWELL_ONE;
                        first_phase <= 1'b0;
                        if (phase == PH_EW_GO) begin
                            cycle_count <= cycle_count + 1'b1;
                        end
                    end
                end

                ST_FAULT: begin
                    state <= ST_FAULT;
                end

                default: begin
                    state <= ST_SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Randomised and directed bench for traffic_light_monitor with a
// phase-level reference model and a per-cycle compare process.
module tb_traffic_light_monitor;

    localparam int MIN_DWELL = 2;
    localparam int MAX_DWELL = 2;
    localparam int DWELL_W   = 4;
    localparam int CNT_W     = 8;

    // Lamp patterns as {NS_g, NS_y, NS_r, EW_g, EW_y, EW_r}
    localparam logic [5:0] P_NS    = 6'b100_001;
    localparam logic [5:0] P_AY    = 6'b010_010;
    localparam logic [5:0] P_EW    = 6'b001_100;
    localparam logic [5:0] P_DARK  = 6'b000_000;
    localparam logic [5:0] P_BOTHG = 6'b100_100;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [1:0]         phase;
    logic               phase_valid;
    logic [DWELL_W-1:0] dwell;
    logic [CNT_W-1:0]   cycle_count;
    logic               fault;
    logic [2:0]         fault_code;

    traffic_light_monitor_if lamps ();

    traffic_light_monitor #(
        .MIN_DWELL (MIN_DWELL),
        .MAX_DWELL (MAX_DWELL),
        .DWELL_W   (DWELL_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lamps       (lamps.slave),
        .phase       (phase),
        .phase_valid (phase_valid),
        .dwell       (dwell),
        .cycle_count (cycle_count),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model state, in plain integers
    int m_valid = 0;
    int m_faulted = 0;
    int m_phase = 0;
    int m_dwell = 0;
    int m_first = 0;
    int m_cnt = 0;
    int m_code = 0;
    int m_p;

    function automatic int decode(input logic [5:0] pat);
        if (pat == P_NS) return 0;
        if (pat == P_AY) return 1;
        if (pat == P_EW) return 2;
        return -1;
    endfunction

    function automatic logic [5:0] pat_of(input int p);
        if (p == 0) return P_NS;
        if (p == 1) return P_AY;
        return P_EW;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_trip(input int code);
        m_faulted = 1;
        m_code    = code;
    endtask

    // Reference model: advance on every rising edge from the sampled lamps
    always @(posedge clk) begin
        m_p = decode({lamps.NS_green, lamps.NS_yellow, lamps.NS_red,
                      lamps.EW_green, lamps.EW_yellow, lamps.EW_red});
        if (reset) begin
            m_valid = 0; m_faulted = 0; m_phase = 0; m_dwell = 0;
            m_first = 0; m_cnt = 0; m_code = 0;
        end else if (m_faulted != 0) begin
            // frozen until reset
        end else if (m_valid == 0) begin
            if (m_p >= 0) begin
                m_valid = 1; m_phase = m_p; m_dwell = 1; m_first = 1;
            end
        end else if (m_p < 0) begin
            m_trip(1);
        end else if (m_p == m_phase) begin
            m_dwell = (m_dwell + 1 > (1 << DWELL_W) - 1) ? (1 << DWELL_W) - 1 : m_dwell + 1;
            if (m_first == 0 && m_dwell > MAX_DWELL) m_trip(4);
        end else if (m_p != (m_phase + 1) % 3) begin
            m_trip(2);
        end else if (m_first == 0 && m_dwell < MIN_DWELL) begin
            m_trip(3);
        end else begin
            if (m_phase == 2) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            m_phase = m_p; m_dwell = 1; m_first = 0;
        end
    end

    // Compare every DUT output against the model on each falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("phase",       int'(phase),       m_phase);
            check("phase_valid", int'(phase_valid), m_valid);
            check("dwell",       int'(dwell),       m_dwell);
            check("cycle_count", int'(cycle_count), m_cnt);
            check("fault",       int'(fault),       m_faulted);
            check("fault_code",  int'(fault_code),  m_code);
        end
    end

    // Drive one sample (at a falling edge) and return at the next falling edge
    task automatic step(input logic [5:0] pat, input logic rst);
        reset = rst;
        {lamps.NS_green, lamps.NS_yellow, lamps.NS_red,
         lamps.EW_green, lamps.EW_yellow, lamps.EW_red} = pat;
        @(negedge clk);
    endtask

    task automatic hold(input logic [5:0] pat, input int n);
        for (int i = 0; i < n; i++) step(pat, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(P_DARK, 1'b1);
    endtask

    task automatic nominal_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            hold(P_NS, 2); hold(P_AY, 2); hold(P_EW, 2);
        end
    endtask

    int rp;
    int left;
    int r;

    initial begin
        @(negedge clk);

        // Nominal sequence
        do_reset(2);
        chk_en = 1'b1;
        check("rst_phase_valid", int'(phase_valid), 0);
        check("rst_fault", int'(fault), 0);
        hold(P_NS, 1);
        check("nom_dwell1", int'(dwell), 1);
        hold(P_NS, 1);
        check("nom_dwell2", int'(dwell), 2);
        hold(P_AY, 2); hold(P_EW, 2);
        nominal_cycles(2);
        hold(P_NS, 1);
        check("nom_cycles", int'(cycle_count), 3);
        check("nom_fault", int'(fault), 0);
        check("nom_valid", int'(phase_valid), 1);
        check("nom_dwell", int'(dwell), 1);

        // Sync with dark lamps, partial first phase
        do_reset(1);
        hold(P_DARK, 5);
        check("sync_dark_valid", int'(phase_valid), 0);
        check("sync_dark_fault", int'(fault), 0);
        hold(P_AY, 1);
        check("sync_valid", int'(phase_valid), 1);
        check("sync_phase_ay", int'(phase), 1);
        hold(P_EW, 1);
        check("sync_phase_ew", int'(phase), 2);
        hold(P_EW, 1);
        check("sync_fault", int'(fault), 0);

        // Illegal combination, later violations do not overwrite
        do_reset(1);
        hold(P_NS, 2);
        hold(P_BOTHG, 1);
        check("illegal_fault", int'(fault), 1);
        check("illegal_code", int'(fault_code), 1);
        hold(P_EW, 1); hold(P_NS, 1); hold(P_AY, 1);
        check("illegal_sticky", int'(fault_code), 1);

        // Bad order
        do_reset(1);
        hold(P_NS, 2);
        hold(P_EW, 1);
        check("order_code", int'(fault_code), 2);
        check("order_phase", int'(phase), 0);

        // Short dwell mid-sequence
        do_reset(1);
        nominal_cycles(1);
        hold(P_NS, 2); hold(P_AY, 1); hold(P_EW, 1);
        check("short_code", int'(fault_code), 3);

        // Long dwell mid-sequence, fault on the third sample
        do_reset(1);
        nominal_cycles(1);
        hold(P_NS, 2);
        check("long_pre_fault", int'(fault), 0);
        hold(P_NS, 1);
        check("long_code", int'(fault_code), 4);

        // Reset while faulted clears everything, then clean resumption
        do_reset(1);
        check("rstf_fault", int'(fault), 0);
        check("rstf_code", int'(fault_code), 0);
        check("rstf_valid", int'(phase_valid), 0);
        check("rstf_dwell", int'(dwell), 0);
        nominal_cycles(1);
        hold(P_NS, 1);
        check("resume_cycles", int'(cycle_count), 1);
        check("resume_fault", int'(fault), 0);

        // Cycle counter wrap
        do_reset(1);
        nominal_cycles(260);
        hold(P_NS, 1);
        check("wrap_cycles", int'(cycle_count), 260 % 256);

        // Randomised controller with occasional misbehaviour
        do_reset(1);
        rp = 0;
        left = 2;
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2 || (m_faulted != 0 && r < 12)) begin
                step(P_DARK, 1'b1);
                rp = int'($urandom_range(0, 2));
                left = int'($urandom_range(1, 3));
            end else if (r < 4) begin
                case ($urandom_range(0, 2))
                    0: step(P_DARK, 1'b0);
                    1: step(P_BOTHG, 1'b0);
                    default: step(6'($urandom_range(0, 63)), 1'b0);
                endcase
            end else if (r < 6) begin
                rp = int'($urandom_range(0, 2));
                step(pat_of(rp), 1'b0);
            end else begin
                step(pat_of(rp), 1'b0);
                left--;
                if (left <= 0) begin
                    rp = (rp + 1) % 3;
                    left = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) * 2 + 1 : 2;
                end
            end
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
